// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Round-robin
// on ties, single-beat transactions with byte enables; illegal accesses never reach memory.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter bit FETCH_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_ack,
  output logic [31:0]       o_f_data,
  output logic              o_f_err,
  input  logic              i_d_req,
  input  logic              i_d_write,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [1:0]        i_d_size,
  output logic              o_d_ack,
  output logic [31:0]       o_d_rdata,
  output logic              o_d_err,
  output logic              o_m_req,
  output logic              o_m_write,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [31:0]       o_m_wdata,
  output logic [3:0]        o_m_be,
  input  logic              i_m_ready,
  input  logic [31:0]       i_m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t      state, state_nx;
  logic        last_d;      // 1: data port holds the most recent grant
  logic        r_d;         // current transaction belongs to the data port
  logic [1:0]  r_off;
  logic [1:0]  r_size;

  logic        grant, grant_d;
  logic        f_bad, d_bad, req_bad;
  logic [3:0]  d_be;
  logic [31:0] d_wdata_sh;
  logic [31:0] ld_sh, ld_data;

  always_comb begin
    grant   = 1'b0;
    grant_d = 1'b0;
    if (state == S_IDLE) begin
      if (i_f_req && i_d_req) begin
        grant   = 1'b1;
        grant_d = ~last_d;
      end else if (i_d_req) begin
        grant   = 1'b1;
        grant_d = 1'b1;
      end else if (i_f_req) begin
        grant   = 1'b1;
      end
    end
  end

  always_comb begin
    f_bad = (i_f_addr[1:0] != 2'b00);
    unique case (i_d_size)
      2'b00:   d_bad = 1'b1;
      2'b01:   d_bad = 1'b0;
      2'b10:   d_bad = i_d_addr[0];
      default: d_bad = (i_d_addr[1:0] != 2'b00);
    endcase
    req_bad = grant_d ? d_bad : f_bad;
  end

  always_comb begin
    unique case (i_d_size)
      2'b01:   d_be = 4'b0001 << i_d_addr[1:0];
      2'b10:   d_be = i_d_addr[1] ? 4'b1100 : 4'b0011;
      default: d_be = 4'b1111;
    endcase
    d_wdata_sh = i_d_wdata << {i_d_addr[1:0], 3'b000};
  end

  // Load data is right-aligned from the captured lane offset, then zero-extended.
  always_comb begin
    ld_sh = i_m_rdata >> {r_off, 3'b000};
    unique case (r_size)
      2'b01:   ld_data = {24'h0, ld_sh[7:0]};
      2'b10:   ld_data = {16'h0, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (grant) state_nx = req_bad ? S_RESP : S_MEM;
      S_MEM:   if (i_m_ready) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_d    <= FETCH_FIRST;
      r_d       <= 1'b0;
      r_off     <= 2'b00;
      r_size    <= 2'b00;
      o_f_ack   <= 1'b0;
      o_f_data  <= '0;
      o_f_err   <= 1'b0;
      o_d_ack   <= 1'b0;
      o_d_rdata <= '0;
      o_d_err   <= 1'b0;
      o_m_req   <= 1'b0;
      o_m_write <= 1'b0;
      o_m_addr  <= '0;
      o_m_wdata <= '0;
      o_m_be    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant) begin
            last_d <= grant_d;
            r_d    <= grant_d;
            r_off  <= i_d_addr[1:0];
            r_size <= i_d_size;
            if (req_bad) begin
              o_f_ack <= ~grant_d;
              o_f_err <= ~grant_d;
              o_d_ack <= grant_d;
              o_d_err <= grant_d;
            end else begin
              o_m_req   <= 1'b1;
              o_m_write <= grant_d & i_d_write;
              o_m_addr  <= grant_d ? {i_d_addr[ADDR_W-1:2], 2'b00}
                                   : {i_f_addr[ADDR_W-1:2], 2'b00};
              o_m_wdata <= grant_d ? d_wdata_sh : 32'h0;
              o_m_be    <= grant_d ? d_be : 4'b1111;
            end
          end
        end
        S_MEM: begin
          if (i_m_ready) begin
            o_m_req   <= 1'b0;
            o_m_write <= 1'b0;
            o_m_addr  <= '0;
            o_m_wdata <= '0;
            o_m_be    <= '0;
            o_f_ack   <= ~r_d;
            o_d_ack   <= r_d;
            if (r_d) o_d_rdata <= ld_data;
            else     o_f_data  <= i_m_rdata;
          end
        end
        S_RESP: begin
          o_f_ack   <= 1'b0;
          o_f_err   <= 1'b0;
          o_f_data  <= '0;
          o_d_ack   <= 1'b0;
          o_d_err   <= 1'b0;
          o_d_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses are queued when a
// request is driven and popped when the matching ack appears.
module tb_mem_port_arbiter;

  logic        i_clk, i_rst;
  logic        i_f_req;
  logic [31:0] i_f_addr;
  logic        o_f_ack;
  logic [31:0] o_f_data;
  logic        o_f_err;
  logic        i_d_req, i_d_write;
  logic [31:0] i_d_addr, i_d_wdata;
  logic [1:0]  i_d_size;
  logic        o_d_ack;
  logic [31:0] o_d_rdata;
  logic        o_d_err;
  logic        o_m_req, o_m_write;
  logic [31:0] o_m_addr, o_m_wdata;
  logic [3:0]  o_m_be;
  logic        i_m_ready;
  logic [31:0] i_m_rdata;

  mem_port_arbiter #(.ADDR_W(32), .FETCH_FIRST(1'b0)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr),
    .o_f_ack(o_f_ack), .o_f_data(o_f_data), .o_f_err(o_f_err),
    .i_d_req(i_d_req), .i_d_write(i_d_write), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_size(i_d_size),
    .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
    .o_m_req(o_m_req), .o_m_write(o_m_write), .o_m_addr(o_m_addr),
    .o_m_wdata(o_m_wdata), .o_m_be(o_m_be),
    .i_m_ready(i_m_ready), .i_m_rdata(i_m_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  // Observations of the last transaction driven by run_txn
  int          obs_lat;
  logic        obs_fack, obs_dack, obs_err, obs_mreq, obs_unstable;
  logic [31:0] obs_data, obs_maddr, obs_mwdata;
  logic        obs_mwrite;
  logic [3:0]  obs_mbe;

  task automatic step;
    @(posedge i_clk); #1;
  endtask

  task automatic run_txn(input logic is_d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input int waits, input logic [31:0] mrdata);
    int w;
    obs_lat = -1; obs_fack = 0; obs_dack = 0; obs_err = 0; obs_data = '0;
    obs_mreq = 0; obs_unstable = 0;
    w = 0;
    if (is_d) begin
      i_d_req = 1; i_d_write = wr; i_d_addr = addr; i_d_wdata = wdata; i_d_size = size;
    end else begin
      i_f_req = 1; i_f_addr = addr;
    end
    for (int c = 1; c <= 20; c++) begin
      step();
      if (o_f_ack || o_d_ack) begin
        obs_lat  = c;
        obs_fack = o_f_ack;
        obs_dack = o_d_ack;
        obs_data = is_d ? o_d_rdata : o_f_data;
        obs_err  = is_d ? o_d_err : o_f_err;
        break;
      end
      if (o_m_req) begin
        if (!obs_mreq) begin
          obs_mreq = 1; obs_mwrite = o_m_write; obs_maddr = o_m_addr;
          obs_mwdata = o_m_wdata; obs_mbe = o_m_be;
        end else if ({o_m_write, o_m_addr, o_m_wdata, o_m_be} !==
                     {obs_mwrite, obs_maddr, obs_mwdata, obs_mbe}) begin
          obs_unstable = 1;
        end
        if (w < waits) begin
          i_m_ready = 0; i_m_rdata = ~mrdata; w++;
        end else begin
          i_m_ready = 1; i_m_rdata = mrdata;
        end
      end
    end
    i_f_req = 0; i_d_req = 0; i_m_ready = 0; i_m_rdata = '0;
    step();
  endtask

  task automatic test_reset;
    i_rst = 1; i_f_req = 0; i_f_addr = '0; i_d_req = 0; i_d_write = 0;
    i_d_addr = '0; i_d_wdata = '0; i_d_size = 2'b00; i_m_ready = 0; i_m_rdata = '0;
    step(); step();
    total++;
    if ({o_m_req, o_m_write, o_m_addr, o_m_wdata, o_m_be} !== '0)
      $display("FAIL reset_mem_outputs: got %h want 0", {o_m_req, o_m_write, o_m_addr, o_m_wdata, o_m_be});
    else passed++;
    total++;
    if ({o_f_ack, o_f_data, o_f_err, o_d_ack, o_d_rdata, o_d_err} !== '0)
      $display("FAIL reset_resp_outputs: got %h want 0", {o_f_ack, o_f_data, o_f_err, o_d_ack, o_d_rdata, o_d_err});
    else passed++;
  endtask

  task automatic test_contention;
    exp_t e;
    int acks;
    i_rst = 1;
    i_f_req = 1; i_f_addr = 32'h10;
    i_d_req = 1; i_d_write = 0; i_d_addr = 32'h20; i_d_size = 2'b11;
    i_m_ready = 1; i_m_rdata = 32'h55AA_33CC;
    step(); step();
    i_rst = 0;
    sb.push_back('{1'b1, 1'b0, 32'h55AA_33CC, 0});
    sb.push_back('{1'b0, 1'b0, 32'h55AA_33CC, 0});
    sb.push_back('{1'b1, 1'b0, 32'h55AA_33CC, 0});
    sb.push_back('{1'b0, 1'b0, 32'h55AA_33CC, 0});
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      step();
      if (o_f_ack || o_d_ack) begin
        e = sb.pop_front();
        acks++;
        total++;
        if ({o_d_ack, o_f_ack} !== {e.is_d, ~e.is_d})
          $display("FAIL contention_order_%0d: got d_ack=%b f_ack=%b want d_ack=%b", acks, o_d_ack, o_f_ack, e.is_d);
        else passed++;
        total++;
        if ((e.is_d ? o_d_rdata : o_f_data) !== e.data)
          $display("FAIL contention_data_%0d: got %h want %h", acks, e.is_d ? o_d_rdata : o_f_data, e.data);
        else passed++;
      end
    end
    total++;
    if (acks != 4) $display("FAIL contention_ack_count: got %0d want 4", acks);
    else passed++;
    sb.delete();
    i_f_req = 0; i_d_req = 0; i_m_ready = 0; i_m_rdata = '0;
    step(); step();
  endtask

  task automatic test_single_fetch;
    exp_t e;
    sb.push_back('{1'b0, 1'b0, 32'hDEAD_BEEF, 2});
    run_txn(1'b0, 1'b0, 32'h100, '0, 2'b11, 0, 32'hDEAD_BEEF);
    e = sb.pop_front();
    total++;
    if ({obs_mreq, obs_mwrite, obs_maddr, obs_mbe} !== {1'b1, 1'b0, 32'h100, 4'b1111})
      $display("FAIL fetch_mem: got req=%b wr=%b addr=%h be=%b want 1 0 00000100 1111", obs_mreq, obs_mwrite, obs_maddr, obs_mbe);
    else passed++;
    total++;
    if ({obs_fack, obs_dack, obs_data, obs_err} !== {1'b1, 1'b0, e.data, e.err} || obs_lat != e.lat)
      $display("FAIL fetch_resp: got ack=%b data=%h err=%b lat=%0d want ack=1 data=%h err=%b lat=%0d", obs_fack, obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
    else passed++;
  endtask

  task automatic test_byte_store;
    exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'h0, 2});
    run_txn(1'b1, 1'b1, 32'h203, 32'h0000_00A5, 2'b01, 0, 32'h0);
    e = sb.pop_front();
    total++;
    if ({obs_mwrite, obs_maddr, obs_mbe, obs_mwdata[31:24]} !== {1'b1, 32'h200, 4'b1000, 8'hA5})
      $display("FAIL byte_store_mem: got wr=%b addr=%h be=%b wdata=%h want 1 00000200 1000 A5xxxxxx", obs_mwrite, obs_maddr, obs_mbe, obs_mwdata);
    else passed++;
    total++;
    if ({obs_dack, obs_err} !== {1'b1, e.err} || obs_lat != e.lat)
      $display("FAIL byte_store_resp: got ack=%b err=%b lat=%0d want ack=1 err=0 lat=%0d", obs_dack, obs_err, obs_lat, e.lat);
    else passed++;
  endtask

  task automatic test_half_store;
    run_txn(1'b1, 1'b1, 32'h206, 32'h0000_BEEF, 2'b10, 0, 32'h0);
    total++;
    if ({obs_maddr, obs_mbe, obs_mwdata[31:16]} !== {32'h204, 4'b1100, 16'hBEEF})
      $display("FAIL half_store_mem: got addr=%h be=%b wdata=%h want 00000204 1100 BEEFxxxx", obs_maddr, obs_mbe, obs_mwdata);
    else passed++;
  endtask

  task automatic test_loads;
    exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'h0000_1234, 4});
    run_txn(1'b1, 1'b0, 32'h302, '0, 2'b10, 2, 32'h1234_ABCD);
    e = sb.pop_front();
    total++;
    if ({obs_mwrite, obs_maddr, obs_mbe, obs_unstable} !== {1'b0, 32'h300, 4'b1100, 1'b0})
      $display("FAIL half_load_mem: got wr=%b addr=%h be=%b unstable=%b want 0 00000300 1100 0", obs_mwrite, obs_maddr, obs_mbe, obs_unstable);
    else passed++;
    total++;
    if ({obs_dack, obs_data, obs_err} !== {1'b1, e.data, e.err} || obs_lat != e.lat)
      $display("FAIL half_load_resp: got data=%h err=%b lat=%0d want %h %b %0d", obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
    else passed++;
    sb.push_back('{1'b1, 1'b0, 32'h0000_0033, 2});
    run_txn(1'b1, 1'b0, 32'h101, '0, 2'b01, 0, 32'h1122_3344);
    e = sb.pop_front();
    total++;
    if ({obs_mbe, obs_data} !== {4'b0010, e.data} || obs_lat != e.lat)
      $display("FAIL byte_load: got be=%b data=%h lat=%0d want 0010 %h %0d", obs_mbe, obs_data, obs_lat, e.data, e.lat);
    else passed++;
    sb.push_back('{1'b1, 1'b0, 32'h0000_ABCD, 2});
    run_txn(1'b1, 1'b0, 32'h300, '0, 2'b10, 0, 32'h1234_ABCD);
    e = sb.pop_front();
    total++;
    if ({obs_mbe, obs_data} !== {4'b0011, e.data})
      $display("FAIL half_load_low: got be=%b data=%h want 0011 %h", obs_mbe, obs_data, e.data);
    else passed++;
  endtask

  task automatic test_illegal;
    exp_t e;
    logic [31:0] a[3] = '{32'h401, 32'h400, 32'h303};
    logic [1:0]  s[3] = '{2'b11, 2'b00, 2'b10};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b1, 1'b1, 32'h0, 1});
      run_txn(1'b1, 1'b0, a[i], '0, s[i], 0, 32'hFFFF_FFFF);
      e = sb.pop_front();
      total++;
      if ({obs_dack, obs_err, obs_data, obs_mreq} !== {1'b1, e.err, e.data, 1'b0} || obs_lat != e.lat)
        $display("FAIL illegal_data_%0d: got ack=%b err=%b data=%h mreq=%b lat=%0d want 1 1 0 0 %0d", i, obs_dack, obs_err, obs_data, obs_mreq, obs_lat, e.lat);
      else passed++;
    end
    sb.push_back('{1'b0, 1'b1, 32'h0, 1});
    run_txn(1'b0, 1'b0, 32'h102, '0, 2'b11, 0, 32'hFFFF_FFFF);
    e = sb.pop_front();
    total++;
    if ({obs_fack, obs_err, obs_data, obs_mreq} !== {1'b1, e.err, e.data, 1'b0} || obs_lat != e.lat)
      $display("FAIL illegal_fetch: got ack=%b err=%b data=%h mreq=%b lat=%0d want 1 1 0 0 %0d", obs_fack, obs_err, obs_data, obs_mreq, obs_lat, e.lat);
    else passed++;
  endtask

  task automatic test_reset_mid_mem;
    exp_t e;
    logic stray;
    i_d_req = 1; i_d_write = 0; i_d_addr = 32'h500; i_d_size = 2'b11; i_m_ready = 0;
    step();
    total++;
    if (o_m_req !== 1'b1) $display("FAIL rst_mid_pre: got m_req=%b want 1", o_m_req);
    else passed++;
    #2 i_rst = 1;
    #1;
    total++;
    if ({o_m_req, o_m_write, o_m_addr, o_m_wdata, o_m_be, o_f_ack, o_d_ack} !== '0)
      $display("FAIL rst_mid_async: got m_req=%b addr=%h be=%b d_ack=%b want all 0", o_m_req, o_m_addr, o_m_be, o_d_ack);
    else passed++;
    i_d_req = 0;
    step();
    i_rst = 0;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (o_f_ack || o_d_ack || o_m_req) stray = 1;
    end
    total++;
    if (stray !== 1'b0) $display("FAIL rst_mid_no_ack: got activity=%b want 0", stray);
    else passed++;
    sb.push_back('{1'b0, 1'b0, 32'hCAFE_F00D, 3});
    run_txn(1'b0, 1'b0, 32'h40, '0, 2'b11, 1, 32'hCAFE_F00D);
    e = sb.pop_front();
    total++;
    if ({obs_fack, obs_data, obs_err, obs_maddr} !== {1'b1, e.data, e.err, 32'h40} || obs_lat != e.lat)
      $display("FAIL rst_mid_recover: got ack=%b data=%h err=%b addr=%h lat=%0d want 1 %h 0 00000040 %0d", obs_fack, obs_data, obs_err, obs_maddr, obs_lat, e.data, e.lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_fetch();
    test_byte_store();
    test_half_store();
    test_loads();
    test_illegal();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
